lcd_timing_ctrl: RTL and testbench

LCD_TIMING_CTRL -- requirements
Module: lcd_timing_ctrl

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_strobe_gen.sv | 88 ++++++++
 rtl/lcd_timing_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_lcd_timing_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus timing controller.
package lcd_pkg;

  localparam int MODE8    = 8;
  localparam int MODE4    = 4;
  localparam int BUSY_BIT = 7;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETUP      = 3'd1,
    EN_HI      = 3'd2,
    HOLD       = 3'd3,
    POLL_SETUP = 3'd4,
    POLL_EN_HI = 3'd5,
    POLL_HOLD  = 3'd6,
    WAIT_REL   = 3'd7
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_AS   = 2'd1,
    PH_PW   = 2'd2,
    PH_H    = 2'd3
  } strobe_phase_t;

  // In 4-bit mode the LCD only listens on DB[7:4].
  function automatic logic [7:0] lane_hi(input logic [3:0] nib);
    return {nib, 4'b0000};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    return m;
  endfunction

endpackage

// File: rtl/lcd_strobe_gen.sv
// One LCD bus cycle: T_AS setup, T_PW enable-high, T_H hold. Shared by data transfers and busy polls.
module lcd_strobe_gen
  import lcd_pkg::*;
#(
  parameter int T_AS = 2,
  parameter int T_PW = 12,
  parameter int T_H  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic en,
  output logic as_end,
  output logic pw_end,
  output logic done
);

  localparam int PH_W = $clog2(max3(T_AS, T_PW, T_H) + 1);

  strobe_phase_t   phase_q, phase_d;
  logic [PH_W-1:0] cnt_q, cnt_d;
  logic            en_q, en_d;

  assign as_end = (phase_q == PH_AS) && (cnt_q == PH_W'(T_AS - 1));
  assign pw_end = (phase_q == PH_PW) && (cnt_q == PH_W'(T_PW - 1));
  assign done   = (phase_q == PH_H)  && (cnt_q == PH_W'(T_H - 1));
  assign en     = en_q;

  // Phase sequencing; a start in the final hold cycle chains straight into the next setup.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    if (start) begin
      phase_d = PH_AS;
      cnt_d   = '0;
      en_d    = 1'b0;
    end else begin
      case (phase_q)
        PH_AS: begin
          if (as_end) begin
            phase_d = PH_PW;
            cnt_d   = '0;
            en_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + PH_W'(1);
          end
        end
        PH_PW: begin
          if (pw_end) begin
            phase_d = PH_H;
            cnt_d   = '0;
            en_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + PH_W'(1);
          end
        end
        PH_H: begin
          if (done) begin
            phase_d = PH_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + PH_W'(1);
          end
        end
        default: begin
          phase_d = PH_IDLE;
          cnt_d   = '0;
          en_d    = 1'b0;
        end
      endcase
    end
  end

  // Phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// Host-strobe to LCD bus bridge: 8/4-bit transfers followed by busy-flag polling with timeout.
module lcd_timing_ctrl
  import lcd_pkg::*;
#(
  parameter int BUS_MODE = MODE8,
  parameter int T_AS     = 2,
  parameter int T_PW     = 12,
  parameter int T_H      = 2,
  parameter int POLL_MAX = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nCS,
  input  logic       nWR,
  input  logic       nRD,
  input  logic       i_RS,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       RDY,
  output logic       TIMEOUT,
  output logic       o_RS,
  output logic       RW,
  output logic       EN,
  output logic [7:0] db_o,
  output logic       db_oe,
  input  logic [7:0] db_i
);

  localparam int PC_W = $clog2(POLL_MAX + 1);
  localparam bit IS4  = (BUS_MODE == MODE4);

  lcd_state_t      state_q, state_d;
  logic            rs_q, rs_d, rw_q, rw_d, oe_q, oe_d;
  logic [7:0]      dbo_q, dbo_d, odata_q, odata_d, dat_q, dat_d, rdbuf_q, rdbuf_d;
  logic            rdy_q, rdy_d, to_q, to_d, is_rd_q, is_rd_d;
  logic            nib_q, nib_d, busy_q, busy_d;
  logic [PC_W-1:0] pcnt_q, pcnt_d;
  logic            sg_start, sg_en, sg_as_end, sg_pw_end, sg_done, last_nib;

  lcd_strobe_gen #(.T_AS(T_AS), .T_PW(T_PW), .T_H(T_H)) u_strobe (
    .clk   (clk),
    .rst   (rst),
    .start (sg_start),
    .en    (sg_en),
    .as_end(sg_as_end),
    .pw_end(sg_pw_end),
    .done  (sg_done)
  );

  assign last_nib = !IS4 || nib_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    rw_d     = rw_q;
    oe_d     = oe_q;
    dbo_d    = dbo_q;
    odata_d  = odata_q;
    rdy_d    = rdy_q;
    to_d     = to_q;
    dat_d    = dat_q;
    is_rd_d  = is_rd_q;
    nib_d    = nib_q;
    busy_d   = busy_q;
    rdbuf_d  = rdbuf_q;
    pcnt_d   = pcnt_q;
    sg_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (!nCS && (nWR != nRD)) begin
          state_d  = SETUP;
          sg_start = 1'b1;
          rdy_d    = 1'b0;
          to_d     = 1'b0;
          rs_d     = i_RS;
          is_rd_d  = !nRD;
          rw_d     = !nRD;
          oe_d     = nRD;
          dat_d    = i_data;
          dbo_d    = IS4 ? lane_hi(i_data[7:4]) : i_data;
          nib_d    = 1'b0;
          busy_d   = 1'b0;
          pcnt_d   = '0;
        end else begin
          rdy_d = 1'b1;
        end
      end
      SETUP: begin
        if (sg_as_end) state_d = EN_HI;
        else state_d = SETUP;
      end
      EN_HI: begin
        if (sg_pw_end) begin
          state_d = HOLD;
          if (is_rd_q && !IS4) rdbuf_d = db_i;
          else if (is_rd_q && !nib_q) rdbuf_d[7:4] = db_i[7:4];
          else if (is_rd_q) rdbuf_d[3:0] = db_i[7:4];
          else rdbuf_d = rdbuf_q;
        end else begin
          state_d = EN_HI;
        end
      end
      HOLD: begin
        if (sg_done && !last_nib) begin
          state_d  = SETUP;
          sg_start = 1'b1;
          nib_d    = 1'b1;
          dbo_d    = lane_hi(dat_q[3:0]);
        end else if (sg_done) begin
          nib_d   = 1'b0;
          odata_d = is_rd_q ? rdbuf_q : odata_q;
          rs_d    = 1'b0;
          rw_d    = 1'b1;
          oe_d    = 1'b0;
          // Instruction reads return the busy flag themselves, so no poll follows.
          if (is_rd_q && !rs_q) begin
            state_d = WAIT_REL;
            rdy_d   = 1'b1;
          end else begin
            state_d  = POLL_SETUP;
            sg_start = 1'b1;
          end
        end else begin
          state_d = HOLD;
        end
      end
      POLL_SETUP: begin
        if (sg_as_end) state_d = POLL_EN_HI;
        else state_d = POLL_SETUP;
      end
      POLL_EN_HI: begin
        if (sg_pw_end) state_d = POLL_HOLD;
        else state_d = POLL_EN_HI;
        if (sg_pw_end && !nib_q) busy_d = db_i[BUSY_BIT];
        else busy_d = busy_q;
      end
      POLL_HOLD: begin
        if (sg_done && !last_nib) begin
          state_d  = POLL_SETUP;
          sg_start = 1'b1;
          nib_d    = 1'b1;
        end else if (sg_done) begin
          nib_d = 1'b0;
          if (!busy_q) begin
            state_d = WAIT_REL;
            rdy_d   = 1'b1;
          end else if (pcnt_q < PC_W'(POLL_MAX)) begin
            state_d  = POLL_SETUP;
            sg_start = 1'b1;
            pcnt_d   = pcnt_q + PC_W'(1);
          end else begin
            state_d = WAIT_REL;
            rdy_d   = 1'b1;
            to_d    = 1'b1;
          end
        end else begin
          state_d = POLL_HOLD;
        end
      end
      WAIT_REL: begin
        if (nCS) state_d = IDLE;
        else state_d = WAIT_REL;
      end
      default: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        rw_d    = 1'b1;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      oe_q    <= 1'b0;
      dbo_q   <= 8'h00;
      odata_q <= 8'h00;
      rdy_q   <= 1'b1;
      to_q    <= 1'b0;
      dat_q   <= 8'h00;
      is_rd_q <= 1'b0;
      nib_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdbuf_q <= 8'h00;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      dbo_q   <= dbo_d;
      odata_q <= odata_d;
      rdy_q   <= rdy_d;
      to_q    <= to_d;
      dat_q   <= dat_d;
      is_rd_q <= is_rd_d;
      nib_q   <= nib_d;
      busy_q  <= busy_d;
      rdbuf_q <= rdbuf_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign o_data  = odata_q;
  assign RDY     = rdy_q;
  assign TIMEOUT = to_q;
  assign o_RS    = rs_q;
  assign RW      = rw_q;
  assign EN      = sg_en;
  assign db_o    = dbo_q;
  assign db_oe   = oe_q;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Scoreboard bench: an 8-bit and a 4-bit controller share the host bus; a monitor checks every EN pulse and completion.
module tb_lcd_timing_ctrl;

  localparam int TPW = 12;

  typedef struct {
    bit         done;
    bit         rs;
    bit         rw;
    bit         oe;
    logic [7:0] dbo;
    logic [7:0] odata;
    bit         to;
    int         gap;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, nCS, nWR, nRD, i_RS, sel;
  logic [7:0] i_data, db_i;
  logic [7:0] od8, od4, dbo8, dbo4;
  logic       rdy8, rdy4, to8, to4, rs8, rs4, rw8, rw4, en8, en4, oe8, oe4;
  logic       ncs8, ncs4;
  logic [7:0] m_odata, m_dbo;
  logic       m_rdy, m_to, m_rs, m_rw, m_en, m_oe;

  ev_t        exp_q[$];
  logic [7:0] resp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign ncs8    = sel ? 1'b1 : nCS;
  assign ncs4    = sel ? nCS : 1'b1;
  assign m_odata = sel ? od4 : od8;
  assign m_dbo   = sel ? dbo4 : dbo8;
  assign m_rdy   = sel ? rdy4 : rdy8;
  assign m_to    = sel ? to4 : to8;
  assign m_rs    = sel ? rs4 : rs8;
  assign m_rw    = sel ? rw4 : rw8;
  assign m_en    = sel ? en4 : en8;
  assign m_oe    = sel ? oe4 : oe8;

  lcd_timing_ctrl #(.BUS_MODE(8), .T_AS(2), .T_PW(12), .T_H(2), .POLL_MAX(3)) u8 (
    .clk(clk), .rst(rst), .nCS(ncs8), .nWR(nWR), .nRD(nRD), .i_RS(i_RS), .i_data(i_data),
    .o_data(od8), .RDY(rdy8), .TIMEOUT(to8), .o_RS(rs8), .RW(rw8), .EN(en8),
    .db_o(dbo8), .db_oe(oe8), .db_i(db_i));

  lcd_timing_ctrl #(.BUS_MODE(4), .T_AS(2), .T_PW(12), .T_H(2), .POLL_MAX(3)) u4 (
    .clk(clk), .rst(rst), .nCS(ncs4), .nWR(nWR), .nRD(nRD), .i_RS(i_RS), .i_data(i_data),
    .o_data(od4), .RDY(rdy4), .TIMEOUT(to4), .o_RS(rs4), .RW(rw4), .EN(en4),
    .db_o(dbo4), .db_oe(oe4), .db_i(db_i));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_pulse(input bit rs, input bit rw, input bit oe, input logic [7:0] dbo, input int gap);
    ev_t e;
    e.done = 1'b0; e.rs = rs; e.rw = rw; e.oe = oe; e.dbo = dbo;
    e.odata = 8'h00; e.to = 1'b0; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_polls(input int n);
    for (int i = 0; i < n; i++) push_pulse(1'b0, 1'b1, 1'b0, 8'h00, 4);
  endtask

  task automatic push_done(input logic [7:0] odata, input bit to);
    ev_t e;
    e.done = 1'b1; e.rs = 1'b0; e.rw = 1'b0; e.oe = 1'b0; e.dbo = 8'h00;
    e.odata = odata; e.to = to; e.gap = 0;
    exp_q.push_back(e);
  endtask

  // Issue one request, keep nCS and the strobe low well past completion, then release.
  task automatic xfer(input bit rd, input bit rs, input logic [7:0] d);
    int n;
    @(posedge clk); #1;
    i_RS = rs; i_data = d; nCS = 1'b0; nWR = rd; nRD = !rd;
    @(posedge clk); #1;
    i_RS = !rs; i_data = ~d;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_events", exp_q.size(), 0);
    repeat (30) @(posedge clk);
    #1 nCS = 1'b1; nWR = 1'b1; nRD = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Monitor: one scoreboard event per EN falling edge and per RDY rising edge.
  initial begin : monitor
    bit en_p, rdy_p, c_rs, c_rw, c_oe, p_rs, p_rw, p_oe, q_rs, q_rw, q_oe;
    logic [7:0] c_dbo, p_dbo, q_dbo;
    int gap, width, c_gap;
    ev_t e;
    en_p = 1'b0; rdy_p = 1'b1; gap = 0; width = 0; c_gap = 0;
    p_rs = 1'b0; p_rw = 1'b1; p_oe = 1'b0; p_dbo = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_p = 1'b0; rdy_p = 1'b1; gap = 0; width = 0;
      end else begin
        if (m_en && !en_p) begin
          c_rs = m_rs; c_rw = m_rw; c_oe = m_oe; c_dbo = m_dbo; c_gap = gap;
          q_rs = p_rs; q_rw = p_rw; q_oe = p_oe; q_dbo = p_dbo;
          width = 1;
        end else if (m_en) begin
          width++;
        end else if (en_p) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind_pulse", 32'd0, 32'(e.done));
            if (!e.done) begin
              chk("pulse_rs", c_rs, e.rs);
              chk("pulse_rw", c_rw, e.rw);
              chk("pulse_oe", c_oe, e.oe);
              chk("en_width", width, TPW);
              chk("setup_gap", c_gap, e.gap);
              chk("setup_rs", q_rs, e.rs);
              chk("setup_rw", q_rw, e.rw);
              chk("setup_oe", q_oe, e.oe);
              if (e.oe) begin
                chk("pulse_db_o", c_dbo, e.dbo);
                chk("setup_db_o", q_dbo, e.dbo);
              end
            end
          end
          gap = 1;
        end else begin
          gap++;
        end
        if (!m_en) begin
          p_rs = m_rs; p_rw = m_rw; p_oe = m_oe; p_dbo = m_dbo;
        end
        if (rdy_p && !m_rdy) gap = 1;
        if (!rdy_p && m_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind_done", 32'd1, 32'(e.done));
            if (e.done) begin
              chk("done_o_data", m_odata, e.odata);
              chk("done_timeout", m_to, e.to);
            end
          end
        end
        en_p = m_en; rdy_p = m_rdy;
      end
    end
  end

  // LCD model: present the next queued byte on db_i at each EN rise.
  initial begin : responder
    bit ep;
    ep = 1'b0;
    forever begin
      @(negedge clk);
      if (m_en && !ep) begin
        if (resp_q.size() > 0) db_i = resp_q.pop_front();
        else db_i = 8'h00;
      end
      ep = rst ? 1'b0 : m_en;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst = 1'b1; nCS = 1'b1; nWR = 1'b1; nRD = 1'b1; i_RS = 1'b0; i_data = 8'h00;
    db_i = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_rdy", m_rdy, 1'b1);
      chk("rst_en", m_en, 1'b0);
      chk("rst_rw", m_rw, 1'b1);
      chk("rst_rs", m_rs, 1'b0);
      chk("rst_oe", m_oe, 1'b0);
      chk("rst_db_o", m_dbo, 8'h00);
      chk("rst_o_data", m_odata, 8'h00);
      chk("rst_timeout", m_to, 1'b0);
    end
    sel = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // 8-bit data write 0x41, one idle poll
    push_pulse(1'b1, 1'b0, 1'b1, 8'h41, 2); push_polls(1); push_done(8'h00, 1'b0);
    xfer(1'b0, 1'b1, 8'h41);
    // instruction write, busy on first poll
    resp_q.push_back(8'h00); resp_q.push_back(8'h80); resp_q.push_back(8'h00);
    push_pulse(1'b0, 1'b0, 1'b1, 8'h01, 2); push_polls(2); push_done(8'h00, 1'b0);
    xfer(1'b0, 1'b0, 8'h01);
    // data read
    resp_q.push_back(8'h5A); resp_q.push_back(8'h00);
    push_pulse(1'b1, 1'b1, 1'b0, 8'h00, 2); push_polls(1); push_done(8'h5A, 1'b0);
    xfer(1'b1, 1'b1, 8'h00);
    // instruction read: no poll
    resp_q.push_back(8'h8C);
    push_pulse(1'b0, 1'b1, 1'b0, 8'h00, 2); push_done(8'h8C, 1'b0);
    xfer(1'b1, 1'b0, 8'h00);
    // stuck busy: four polls then timeout, o_data untouched
    resp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) resp_q.push_back(8'h80);
    push_pulse(1'b1, 1'b0, 1'b1, 8'h55, 2); push_polls(4); push_done(8'h8C, 1'b1);
    xfer(1'b0, 1'b1, 8'h55);
    chk("timeout_sticky", m_to, 1'b1);
    // next request clears TIMEOUT
    push_pulse(1'b1, 1'b0, 1'b1, 8'h00, 2); push_polls(1); push_done(8'h8C, 1'b0);
    xfer(1'b0, 1'b1, 8'h00);

    // both strobes low: nothing happens
    @(posedge clk); #1 nCS = 1'b0; nWR = 1'b0; nRD = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("both_strobes_rdy", m_rdy, 1'b1);
    chk("both_strobes_en", m_en, 1'b0);
    nCS = 1'b1; nWR = 1'b1; nRD = 1'b1;
    repeat (2) @(posedge clk);

    // 4-bit write 0xA5
    #1 sel = 1'b1;
    push_pulse(1'b1, 1'b0, 1'b1, 8'hA0, 2); push_pulse(1'b1, 1'b0, 1'b1, 8'h50, 4);
    push_polls(2); push_done(8'h00, 1'b0);
    xfer(1'b0, 1'b1, 8'hA5);
    // 4-bit data read 0x30 / 0x90 -> 0x39
    resp_q.push_back(8'h30); resp_q.push_back(8'h90); resp_q.push_back(8'h00); resp_q.push_back(8'h00);
    push_pulse(1'b1, 1'b1, 1'b0, 8'h00, 2); push_pulse(1'b1, 1'b1, 1'b0, 8'h00, 4);
    push_polls(2); push_done(8'h39, 1'b0);
    xfer(1'b1, 1'b1, 8'h00);
    // 4-bit busy taken from the first pulse of each poll only
    resp_q.push_back(8'h00); resp_q.push_back(8'h00);
    resp_q.push_back(8'h80); resp_q.push_back(8'h00); resp_q.push_back(8'h00); resp_q.push_back(8'h80);
    push_pulse(1'b0, 1'b0, 1'b1, 8'h20, 2); push_pulse(1'b0, 1'b0, 1'b1, 8'h80, 4);
    push_polls(4); push_done(8'h39, 1'b0);
    xfer(1'b0, 1'b0, 8'h28);

    // reset during EN_HI on the 8-bit unit
    @(posedge clk); #1 sel = 1'b0;
    i_RS = 1'b1; i_data = 8'h33; nCS = 1'b0; nWR = 1'b0; nRD = 1'b1;
    n = 0;
    while (!m_en && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_en_seen", m_en, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; nCS = 1'b1; nWR = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_en", m_en, 1'b0);
    chk("abort_rdy", m_rdy, 1'b1);
    chk("abort_oe", m_oe, 1'b0);
    chk("abort_o_data", m_odata, 8'h00);
    repeat (2) @(posedge clk);
    push_pulse(1'b1, 1'b0, 1'b1, 8'h7E, 2); push_polls(1); push_done(8'h00, 1'b0);
    xfer(1'b0, 1'b1, 8'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
